noc_rr_arbiter: RTL and testbench

Parametrised output-port arbiter for the NoC router, successor to the fixed 5-port timed arbiter. It grants one of NPORTS input channels at a time, holding the grant while the channel keeps requesting and its per-channel packet timer has not expired. Both grant policies are available: rotating (round-robin) and fixed priority. It also provides a registered one-hot grant, an encoded grant index and per-port timeout pulses for the crossbar and the error counters.

---
 rtl/noc_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_noc_rr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - NoC output-port arbiter with per-channel tenure timers
`timescale 1ns/1ps

module noc_rr_arbiter #(
    parameter int NPORTS  = 5,
    parameter int LEN_W   = 12,
    parameter int FID_W   = 3,
    parameter int HEAD_ID = 1,
    parameter int RR_MODE = 1,
    parameter int IDX_W   = $clog2(NPORTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         req,
    input  logic [NPORTS*FID_W-1:0]   flit_id,
    input  logic [NPORTS*LEN_W-1:0]   length,
    output logic [NPORTS-1:0]         grant,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      idle,
    output logic [NPORTS-1:0]         timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ILLEGAL
    } state_e;

    state_e                 state;

    logic [NPORTS-1:0]      grant_q, grant_d;
    logic [NPORTS-1:0]      timeout_q, timeout_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic                   idle_q, idle_d;
    logic [LEN_W-1:0]       cnt_q   [NPORTS];
    logic [LEN_W-1:0]       cnt_d   [NPORTS];
    logic [LEN_W-1:0]       limit_q [NPORTS];
    logic [LEN_W-1:0]       limit_d [NPORTS];

    logic                   hold;
    logic                   expired;
    logic                   found;
    logic [IDX_W-1:0]       win;
    logic [IDX_W:0]         cand;

    // The grant register is the state; anything not zero/one-hot is illegal.
    always_comb begin
        if (grant_q == '0) begin
            state = ST_IDLE;
        end else if ($onehot(grant_q)) begin
            state = ST_GRANT;
        end else begin
            state = ST_ILLEGAL;
        end
    end

    // Widened compare keeps cnt+1 from wrapping at the top of the counter range.
    always_comb begin
        hold    = 1'b0;
        expired = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_q[i]) begin
                hold = req[i] &&
                       ((limit_q[i] == '0) ||
                        (({1'b0, cnt_q[i]} + (LEN_W+1)'(1)) < {1'b0, limit_q[i]}));
                expired = req[i] && !hold;
            end
        end
    end

    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        if (RR_MODE != 0) begin
            // Starting after last puts the previous holder at lowest priority.
            for (int off = 1; off <= NPORTS; off++) begin
                cand = {1'b0, last_q} + (IDX_W+1)'(off);
                if (cand >= (IDX_W+1)'(NPORTS)) begin
                    cand = cand - (IDX_W+1)'(NPORTS);
                end
                if (!found && req[cand[IDX_W-1:0]]) begin
                    found = 1'b1;
                    win   = cand[IDX_W-1:0];
                end
            end
        end else begin
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    found = 1'b1;
                    win   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        grant_d   = '0;
        idx_d     = '0;
        last_d    = last_q;
        timeout_d = '0;
        for (int i = 0; i < NPORTS; i++) begin
            cnt_d[i] = '0;
            if (flit_id[i*FID_W +: FID_W] == FID_W'(HEAD_ID)) begin
                limit_d[i] = length[i*LEN_W +: LEN_W];
            end else begin
                limit_d[i] = limit_q[i];
            end
        end

        case (state)
            ST_GRANT: begin
                if (hold) begin
                    grant_d = grant_q;
                    idx_d   = idx_q;
                    for (int i = 0; i < NPORTS; i++) begin
                        if (grant_q[i]) begin
                            cnt_d[i] = (limit_q[i] == '0) ? cnt_q[i]
                                                          : cnt_q[i] + LEN_W'(1);
                        end
                    end
                end else begin
                    if (expired) begin
                        timeout_d = grant_q;
                    end
                    if (found) begin
                        grant_d = NPORTS'(1) << win;
                        idx_d   = win;
                        last_d  = win;
                    end
                end
            end
            ST_IDLE: begin
                if (found) begin
                    grant_d = NPORTS'(1) << win;
                    idx_d   = win;
                    last_d  = win;
                end
            end
            default: begin
            end
        endcase

        idle_d = (grant_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q   <= '0;
            timeout_q <= '0;
            idx_q     <= '0;
            last_q    <= IDX_W'(NPORTS - 1);
            idle_q    <= 1'b1;
            for (int i = 0; i < NPORTS; i++) begin
                cnt_q[i]   <= '0;
                limit_q[i] <= '0;
            end
        end else begin
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            idle_q    <= idle_d;
            for (int i = 0; i < NPORTS; i++) begin
                cnt_q[i]   <= cnt_d[i];
                limit_q[i] <= limit_d[i];
            end
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign idle      = idle_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// tb/tb_noc_rr_arbiter.sv - directed checks for noc_rr_arbiter in both grant policies
`timescale 1ns/1ps

module tb_noc_rr_arbiter;

    localparam int NP = 5;
    localparam int LW = 12;
    localparam int FW = 3;

    typedef struct {
        bit          rst_before;
        logic [4:0]  req;
        logic [4:0]  hdr;
        logic [11:0] len;
        logic [4:0]  g_rr;
        logic [4:0]  to_rr;
        logic [4:0]  g_fx;
        logic [4:0]  to_fx;
    } vec_t;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     req;
    logic [NP*FW-1:0]  flit_id;
    logic [NP*LW-1:0]  length;

    logic [NP-1:0]     g_rr, to_rr, g_fx, to_fx;
    logic [2:0]        ix_rr, ix_fx;
    logic              il_rr, il_fx;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    noc_rr_arbiter #(.NPORTS(NP), .LEN_W(LW), .FID_W(FW), .HEAD_ID(1), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
        .grant(g_rr), .grant_idx(ix_rr), .idle(il_rr), .timeout(to_rr)
    );

    noc_rr_arbiter #(.NPORTS(NP), .LEN_W(LW), .FID_W(FW), .HEAD_ID(1), .RR_MODE(0)) u_fx (
        .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
        .grant(g_fx), .grant_idx(ix_fx), .idle(il_fx), .timeout(to_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] oh2idx(input logic [4:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [4:0] g, input logic [2:0] ix,
                         input logic il, input logic [4:0] to,
                         input logic [4:0] eg, input logic [4:0] eto);
        logic [2:0] eix;
        logic       eil;
        eix = oh2idx(eg);
        eil = (eg == 5'b0);
        n_tests++;
        if ({g, ix, il, to} !== {eg, eix, eil, eto}) begin
            n_fail++;
            $display("FAIL %s: got grant=%b idx=%0d idle=%b timeout=%b, want grant=%b idx=%0d idle=%b timeout=%b",
                     name, g, ix, il, to, eg, eix, eil, eto);
        end
    endtask

    task automatic check_both(input string name, input logic [4:0] eg_rr, input logic [4:0] eto_rr,
                              input logic [4:0] eg_fx, input logic [4:0] eto_fx);
        check({name, "/rr"}, g_rr, ix_rr, il_rr, to_rr, eg_rr, eto_rr);
        check({name, "/fx"}, g_fx, ix_fx, il_fx, to_fx, eg_fx, eto_fx);
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] hdr, input logic [11:0] len);
        req = r;
        for (int ch = 0; ch < NP; ch++) begin
            flit_id[ch*FW +: FW] = hdr[ch] ? 3'd1 : 3'd0;
            length[ch*LW +: LW]  = len;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(5'b0, 5'b0, 12'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic add(input bit rb, input logic [4:0] r, input logic [4:0] h, input logic [11:0] l,
                       input logic [4:0] grr, input logic [4:0] trr,
                       input logic [4:0] gfx, input logic [4:0] tfx);
        vec_t v;
        v.rst_before = rb; v.req = r; v.hdr = h; v.len = l;
        v.g_rr = grr; v.to_rr = trr; v.g_fx = gfx; v.to_fx = tfx;
        vecs.push_back(v);
    endtask

    initial begin
        logic [4:0] rr_g  [11];
        logic [4:0] rr_to [11];
        logic [4:0] fr_g  [6];
        logic [4:0] fr_to [6];

        // Expiry: single requester ch1, limit 4, re-tenure after each timeout.
        for (int e = 0; e < 9; e++) begin
            add(e == 0, 5'b00010, (e == 0) ? 5'b00010 : 5'b0, 12'd4,
                5'b00010, (e == 4 || e == 8) ? 5'b00010 : 5'b0,
                5'b00010, (e == 4 || e == 8) ? 5'b00010 : 5'b0);
        end

        // All requesting, limit 2: RR rotates, fixed keeps ch0.
        rr_g  = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd4, 5'd4, 5'd8, 5'd8, 5'd16, 5'd16, 5'd1};
        rr_to = '{5'd0, 5'd0, 5'd1, 5'd0, 5'd2, 5'd0, 5'd4, 5'd0, 5'd8,  5'd0,  5'd16};
        for (int e = 0; e < 11; e++) begin
            add(e == 0, 5'b11111, (e == 0) ? 5'b11111 : 5'b0, 12'd2,
                rr_g[e], rr_to[e], 5'b00001, (e >= 2 && e[0] == 1'b0) ? 5'b00001 : 5'b0);
        end

        // req=10110, limit 1: fixed re-grants ch1 every cycle, RR cycles 1,2,4.
        fr_g  = '{5'b00010, 5'b00100, 5'b10000, 5'b00010, 5'b00100, 5'b10000};
        fr_to = '{5'b00000, 5'b00010, 5'b00100, 5'b10000, 5'b00010, 5'b00100};
        for (int e = 0; e < 6; e++) begin
            add(e == 0, 5'b10110, (e == 0) ? 5'b11111 : 5'b0, 12'd1,
                fr_g[e], fr_to[e], 5'b00010, (e == 0) ? 5'b0 : 5'b00010);
        end

        rst = 1'b0;
        req = 5'($urandom);
        flit_id = '0;
        length  = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            req = 5'($urandom);
            check_both($sformatf("reset_hold%0d", c), 5'b0, 5'b0, 5'b0, 5'b0);
        end
        req = 5'b00100;
        #2;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_both($sformatf("first_grant%0d", c), 5'b00100, 5'b0, 5'b00100, 5'b0);
        end
        #2;
        rst = 1'b0;
        #1;
        check_both("async_reset", 5'b0, 5'b0, 5'b0, 5'b0);
        req = 5'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_both("idle_after_reset", 5'b0, 5'b0, 5'b0, 5'b0);

        for (int n = 0; n < vecs.size(); n++) begin
            if (vecs[n].rst_before) do_reset();
            drive(vecs[n].req, vecs[n].hdr, vecs[n].len);
            @(posedge clk);
            #1;
            check_both($sformatf("vec%0d", n), vecs[n].g_rr, vecs[n].to_rr, vecs[n].g_fx, vecs[n].to_fx);
        end

        // Unlimited tenure on ch3, then drop with ch0 waiting, then nobody.
        do_reset();
        drive(5'b01000, 5'b01000, 12'd0);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            drive(5'b01000, 5'b0, 12'd0);
            check_both($sformatf("unlimited%0d", c), 5'b01000, 5'b0, 5'b01000, 5'b0);
        end
        drive(5'b00001, 5'b0, 12'd0);
        @(posedge clk);
        #1;
        check_both("drop_handover", 5'b00001, 5'b0, 5'b00001, 5'b0);
        drive(5'b00000, 5'b0, 12'd0);
        @(posedge clk);
        #1;
        check_both("drop_to_idle", 5'b0, 5'b0, 5'b0, 5'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
